// File: rtl/calc_pkg.sv
// Shared definitions for the calculator-unit scheduler.
//   OP_*   : opcode encodings presented on ReqOp/UOp
//   CA_*   : scheduler state encoding
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    CA_IDLE  = 2'd0,
    CA_ISSUE = 2'd1,
    CA_WAIT  = 2'd2,
    CA_RESP  = 2'd3
  } ca_state_e;

endpackage

// File: rtl/calc_arbiter_if.sv
// Bundle of requester-side and unit-side signals around the scheduler.
//   slave  : scheduler view (takes requests and unit results, drives grants,
//            responses and unit commands)
//   master : environment view (requesters plus arithmetic unit)
interface calc_arbiter_if #(
  parameter int unsigned W = 11
);

  logic         ReqValid0, ReqValid1;
  logic         ReqReady0, ReqReady1;
  logic [1:0]   ReqOp0,    ReqOp1;
  logic [W-1:0] ReqA0,     ReqA1;
  logic [W-1:0] ReqB0,     ReqB1;

  logic         RspValid0, RspValid1;
  logic [W-1:0] RspResult;
  logic         RspOvf;

  logic         UStart;
  logic [1:0]   UOp;
  logic [W-1:0] UA, UB;
  logic         UDone;
  logic [W-1:0] UResult;
  logic         UOvf;
  logic         UAbort;

  modport slave (
    input  ReqValid0, ReqValid1, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1,
    output ReqReady0, ReqReady1,
    output RspValid0, RspValid1, RspResult, RspOvf,
    output UStart, UOp, UA, UB, UAbort,
    input  UDone, UResult, UOvf
  );

  modport master (
    output ReqValid0, ReqValid1, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1,
    input  ReqReady0, ReqReady1,
    input  RspValid0, RspValid1, RspResult, RspOvf,
    input  UStart, UOp, UA, UB, UAbort,
    output UDone, UResult, UOvf
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   req   : request vector
//   ptr   : preferred requester when both request
//   gnt   : one-hot grant (zero when nobody requests)
//   owner : index of the granted requester
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       owner
);

  always_comb begin
    owner = 1'b0;
    gnt   = 2'b00;
    case (req)
      2'b01:   owner = 1'b0;
      2'b10:   owner = 1'b1;
      2'b11:   owner = ptr;
      default: owner = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt = owner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one multi-cycle arithmetic unit between two requesters: round-robin
// grant, start/done handshake with the unit, completion timeout with abort,
// and routing of result/overflow back to the owning requester.
//   Clock, Clear : clock and asynchronous active-high reset
//   bus          : requester handshakes, response pulses, unit command/result
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned W   = 11,
  parameter int unsigned TMO = 2048
) (
  input  logic          Clock,
  input  logic          Clear,
  calc_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TMO + 1);

  ca_state_e    state;
  logic         ptr;
  logic         owner_q;
  logic [1:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] res_q;
  logic         ovf_q;
  logic [TW-1:0] timer;
  logic         ustart_q;
  logic [1:0]   rsp_q;

  logic [1:0]   gnt;
  logic         win;
  logic         timeout_c;

  rr_arbiter2 u_rr (
    .req   ({bus.ReqValid1, bus.ReqValid0}),
    .ptr   (ptr),
    .gnt   (gnt),
    .owner (win)
  );

  // Abort fires in the last WAIT cycle only when the unit is not finishing now
  assign timeout_c = (state == CA_WAIT) && !bus.UDone && (timer == TW'(1));

  // Grants and abort are combinational; gate with Clear so outputs read 0 in reset
  assign bus.ReqReady0 = !Clear && (state == CA_IDLE) && gnt[0];
  assign bus.ReqReady1 = !Clear && (state == CA_IDLE) && gnt[1];
  assign bus.UAbort    = !Clear && timeout_c;

  assign bus.UStart    = ustart_q;
  assign bus.UOp       = op_q;
  assign bus.UA        = a_q;
  assign bus.UB        = b_q;
  assign bus.RspValid0 = rsp_q[0];
  assign bus.RspValid1 = rsp_q[1];
  assign bus.RspResult = res_q;
  assign bus.RspOvf    = ovf_q;

  // Scheduler FSM with capture, timer and result registers
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= CA_IDLE;
      ptr      <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      timer    <= '0;
      ustart_q <= 1'b0;
      rsp_q    <= 2'b00;
    end else begin
      ustart_q <= 1'b0;
      rsp_q    <= 2'b00;
      case (state)
        CA_IDLE: begin
          if (gnt != 2'b00) begin
            owner_q  <= win;
            op_q     <= win ? bus.ReqOp1 : bus.ReqOp0;
            a_q      <= win ? bus.ReqA1  : bus.ReqA0;
            b_q      <= win ? bus.ReqB1  : bus.ReqB0;
            ustart_q <= 1'b1;
            state    <= CA_ISSUE;
          end
        end
        CA_ISSUE: begin
          timer <= TW'(TMO);
          state <= CA_WAIT;
        end
        CA_WAIT: begin
          if (bus.UDone) begin
            res_q <= bus.UResult;
            ovf_q <= bus.UOvf;
            rsp_q <= owner_q ? 2'b10 : 2'b01;
            state <= CA_RESP;
          end else if (timer == TW'(1)) begin
            res_q <= '0;
            ovf_q <= 1'b1;
            rsp_q <= owner_q ? 2'b10 : 2'b01;
            state <= CA_RESP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        CA_RESP: begin
          ptr   <= ~owner_q;
          state <= CA_IDLE;
        end
        default: state <= CA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: directed requests, a behavioural unit model, and a
// per-cycle timestamp-based reference of the scheduler's observable behaviour.
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int unsigned W   = 11;
  localparam int unsigned TMO = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic Clock;
  logic Clear;

  calc_arbiter_if #(.W(W)) bus ();

  calc_arbiter #(.W(W), .TMO(TMO)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int cyc = 0;
  initial forever begin
    @(posedge Clock);
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unit model controls
  int  u_lat = 0;
  bit  stray_done = 1'b0;

  function automatic logic [W:0] ucalc(input logic [1:0] op,
                                       input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
    int x, y, r;
    x = a;
    y = b;
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_MUL: r = x * y;
      default: begin
        if (y == 0) return {1'b1, W'(0)};
        r = x / y;
      end
    endcase
    return {(r > MAXV) || (r < MINV), W'(r)};
  endfunction

  // Arithmetic unit model: answers in its u_lat-th WAIT cycle (never when 0)
  initial begin
    int w;
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic [W:0] r;
    w = 0; op = '0; a = '0; b = '0;
    bus.UDone = 1'b0; bus.UResult = '0; bus.UOvf = 1'b0;
    forever begin
      @(negedge Clock);
      if (Clear) w = 0;
      else if (bus.UStart) begin w = 1; op = bus.UOp; a = bus.UA; b = bus.UB; end
      else if (bus.UDone || bus.UAbort) w = 0;
      else if (w != 0) w++;
      @(posedge Clock);
      #2;
      if (w != 0 && w == u_lat) begin
        r = ucalc(op, a, b);
        bus.UDone = 1'b1; bus.UResult = r[W-1:0]; bus.UOvf = r[W];
      end else if (stray_done) begin
        bus.UDone = 1'b1; bus.UResult = W'(11'h555); bus.UOvf = 1'b1;
      end else begin
        bus.UDone = 1'b0; bus.UResult = '0; bus.UOvf = 1'b0;
      end
    end
  end

  // Observed event log
  int acc_cyc, ustart_cyc, abort_cyc, rsp_cyc;
  bit acc_id, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_res;
  int n_rsp = 0, n_abort = 0;
  bit gnt_log[$];
  int gnt_cyc[$];
  bit rsp_log[$];

  // Reference: one command at a time, tracked by its accept cycle
  bit m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, m_ovf = 1'b0;
  int m_acc = 0, m_resp = 0;
  logic [1:0] m_op;
  logic [W-1:0] m_a, m_b, m_res;

  initial forever begin
    logic [1:0] exp_rdy, exp_rv;
    bit exp_start, exp_abort, in_wait, was_busy;
    @(negedge Clock);
    if (Clear) begin
      check("reset_outputs",
            32'({bus.ReqReady1, bus.ReqReady0, bus.RspValid1, bus.RspValid0, bus.RspOvf,
                 bus.UStart, bus.UAbort, bus.UOp}) | 32'(bus.RspResult) | 32'(bus.UA) | 32'(bus.UB),
            32'd0);
      m_busy = 1'b0; m_ptr = 1'b0;
    end else begin
      was_busy = m_busy;
      exp_rdy = 2'b00;
      if (!m_busy) begin
        if (bus.ReqValid0 && bus.ReqValid1) exp_rdy = m_ptr ? 2'b10 : 2'b01;
        else exp_rdy = {bus.ReqValid1, bus.ReqValid0};
      end
      exp_start = m_busy && (cyc == m_acc + 1);
      in_wait   = m_busy && (m_resp == 0) && (cyc >= m_acc + 2);
      exp_abort = in_wait && !bus.UDone && (cyc == m_acc + 1 + int'(TMO));
      exp_rv    = (m_busy && m_resp == cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;

      check("req_ready", 32'({bus.ReqReady1, bus.ReqReady0}), 32'(exp_rdy));
      check("u_start",   32'(bus.UStart), 32'(exp_start));
      check("u_abort",   32'(bus.UAbort), 32'(exp_abort));
      check("rsp_valid", 32'({bus.RspValid1, bus.RspValid0}), 32'(exp_rv));
      if (exp_rv != 2'b00) begin
        check("rsp_result", 32'(bus.RspResult), 32'(m_res));
        check("rsp_ovf",    32'(bus.RspOvf), 32'(m_ovf));
      end
      if (m_busy && cyc >= m_acc + 1)
        check("u_cmd", 32'({bus.UOp, bus.UA, bus.UB}), 32'({m_op, m_a, m_b}));

      if (bus.ReqReady0 || bus.ReqReady1) begin
        acc_cyc = cyc; acc_id = bus.ReqReady1;
        gnt_log.push_back(bus.ReqReady1); gnt_cyc.push_back(cyc);
      end
      if (bus.UStart) ustart_cyc = cyc;
      if (bus.UAbort) begin abort_cyc = cyc; n_abort++; end
      if (bus.RspValid0 || bus.RspValid1) begin
        rsp_cyc = cyc; rsp_id = bus.RspValid1; rsp_res = bus.RspResult; rsp_ovf = bus.RspOvf;
        rsp_log.push_back(bus.RspValid1); n_rsp++;
      end

      if (exp_rv != 2'b00) begin
        m_busy = 1'b0; m_ptr = ~m_owner;
      end else if (in_wait && bus.UDone) begin
        m_resp = cyc + 1; m_res = bus.UResult; m_ovf = bus.UOvf;
      end else if (exp_abort) begin
        m_resp = cyc + 1; m_res = '0; m_ovf = 1'b1;
      end
      if (!was_busy && exp_rdy != 2'b00) begin
        m_busy = 1'b1; m_acc = cyc; m_resp = 0; m_owner = exp_rdy[1];
        m_op = m_owner ? bus.ReqOp1 : bus.ReqOp0;
        m_a  = m_owner ? bus.ReqA1  : bus.ReqA0;
        m_b  = m_owner ? bus.ReqB1  : bus.ReqB0;
      end
    end
  end

  int raise_cyc;

  task automatic set_req(input bit id, input bit v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin bus.ReqValid1 = v; bus.ReqOp1 = op; bus.ReqA1 = a; bus.ReqB1 = b; end
    else    begin bus.ReqValid0 = v; bus.ReqOp0 = op; bus.ReqA0 = a; bus.ReqB0 = b; end
  endtask

  task automatic send(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    raise_cyc = cyc;
    set_req(id, 1'b1, op, a, b);
    for (int k = 0; k < 50; k++) begin
      @(negedge Clock);
      if (id ? bus.ReqReady1 : bus.ReqReady0) begin got = 1'b1; break; end
    end
    check("grant_seen", 32'(got), 32'd1);
    @(posedge Clock);
    #1;
    set_req(id, 1'b0, op, a, b);
  endtask

  task automatic wait_grants(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge Clock);
      if (gnt_log.size() >= target) begin ok = 1'b1; break; end
    end
    #1;
    check("grant_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge Clock);
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
    #1;
    check("rsp_wait", 32'(ok), 32'd1);
  endtask

  task automatic do_clear();
    @(posedge Clock);
    #1 Clear = 1'b1;
    @(posedge Clock);
    #1 Clear = 1'b0;
  endtask

  initial begin
    int n0;
    Clear = 1'b1;
    set_req(1'b0, 1'b0, OP_ADD, '0, '0);
    set_req(1'b1, 1'b0, OP_ADD, '0, '0);
    repeat (3) @(posedge Clock);
    #1 Clear = 1'b0;

    // Single add: 5 + 7, unit answers in its 3rd WAIT cycle
    u_lat = 3;
    send(1'b0, OP_ADD, 11'd5, 11'd7);
    wait_rsp(n_rsp + 1);
    check("t1_ustart_lat", 32'(ustart_cyc - acc_cyc), 32'd1);
    check("t1_rsp_lat",    32'(rsp_cyc - acc_cyc), 32'd5);
    check("t1_result",     32'(rsp_res), 32'd12);
    check("t1_ovf",        32'(rsp_ovf), 32'd0);
    check("t1_rsp_id",     32'(rsp_id), 32'd0);

    // Contention after reset: both valid, 3 * -4
    do_clear();
    gnt_log.delete(); gnt_cyc.delete(); rsp_log.delete();
    u_lat = 1;
    n0 = n_rsp;
    set_req(1'b0, 1'b1, OP_MUL, 11'd3, 11'h7FC);
    set_req(1'b1, 1'b1, OP_MUL, 11'd3, 11'h7FC);
    wait_grants(4);
    set_req(1'b0, 1'b0, OP_MUL, 11'd3, 11'h7FC);
    set_req(1'b1, 1'b0, OP_MUL, 11'd3, 11'h7FC);
    wait_rsp(n0 + 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_grant_order", 32'(gnt_log[i]), 32'(i % 2));
      check("t2_rsp_order",   32'(rsp_log[i]), 32'(i % 2));
    end
    check("t2_throughput", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd4);
    check("t2_result",     32'(rsp_res), 32'h7F4);

    // Timeout: div by zero, unit never answers
    u_lat = 0;
    n0 = n_abort;
    send(1'b1, OP_DIV, 11'd100, 11'd0);
    wait_rsp(n_rsp + 1);
    check("t3_abort_cyc", 32'(abort_cyc - acc_cyc), 32'd17);
    check("t3_abort_cnt", 32'(n_abort - n0), 32'd1);
    check("t3_rsp_lat",   32'(rsp_cyc - acc_cyc), 32'd18);
    check("t3_rsp_id",    32'(rsp_id), 32'd1);
    check("t3_result",    32'(rsp_res), 32'd0);
    check("t3_ovf",       32'(rsp_ovf), 32'd1);

    // Done in the same cycle the timer expires: done wins
    u_lat = TMO;
    n0 = n_abort;
    send(1'b0, OP_ADD, 11'd4, 11'd5);
    wait_rsp(n_rsp + 1);
    check("t4_no_abort", 32'(n_abort - n0), 32'd0);
    check("t4_rsp_lat",  32'(rsp_cyc - acc_cyc), 32'd18);
    check("t4_result",   32'(rsp_res), 32'd9);
    check("t4_ovf",      32'(rsp_ovf), 32'd0);

    // Clear during WAIT: request lost, pointer back to 0
    u_lat = 0;
    send(1'b0, OP_SUB, 11'd1, 11'd1);
    n0 = n_rsp;
    repeat (3) @(posedge Clock);
    do_clear();
    repeat (20) @(posedge Clock);
    #1;
    check("t5_no_rsp", 32'(n_rsp - n0), 32'd0);
    u_lat = 1;
    set_req(1'b0, 1'b1, OP_ADD, 11'd2, 11'd2);
    set_req(1'b1, 1'b1, OP_ADD, 11'd2, 11'd2);
    wait_grants(gnt_log.size() + 1);
    set_req(1'b0, 1'b0, OP_ADD, 11'd2, 11'd2);
    set_req(1'b1, 1'b0, OP_ADD, 11'd2, 11'd2);
    check("t5_ptr_reset", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);
    wait_rsp(n_rsp + 1);
    send(1'b1, OP_ADD, 11'd1, 11'd2);
    check("t5_grant_at_once", 32'(acc_cyc - raise_cyc), 32'd0);
    wait_rsp(n_rsp + 1);
    check("t5_result", 32'(rsp_res), 32'd3);

    // Stray UDone in IDLE, then in ISSUE
    n0 = n_rsp;
    @(posedge Clock);
    #1 stray_done = 1'b1;
    @(posedge Clock);
    #1 stray_done = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("t6_idle_stray", 32'(n_rsp - n0), 32'd0);
    u_lat = 2;
    send(1'b0, OP_SUB, 11'd20, 11'd7);
    stray_done = 1'b1;
    @(posedge Clock);
    #1 stray_done = 1'b0;
    wait_rsp(n_rsp + 1);
    check("t6_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd4);
    check("t6_result",  32'(rsp_res), 32'd13);
    check("t6_ovf",     32'(rsp_ovf), 32'd0);
    check("t6_rsp_id",  32'(rsp_id), 32'd0);

    repeat (3) @(posedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1);
  end

endmodule
